// File: rtl/ita_output_writer.sv
// Writes the ITA output stream to memory as a 2-D tile of beats, with a 2-entry
// skid buffer between the accelerator handshake and the req/gnt write port.
module ita_output_writer #(
    parameter int N  = 16,
    parameter int WI = 8,
    parameter int AW = 32,
    parameter int DW = N * WI,
    parameter int CW = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [AW-1:0]   base_addr_i,
    input  logic [AW-1:0]   row_stride_i,
    input  logic [CW-1:0]   tile_rows_i,
    input  logic [CW-1:0]   tile_cols_i,
    input  logic            inp_valid_i,
    output logic            inp_ready_o,
    input  logic [DW-1:0]   inp_data_i,
    output logic            mem_req_o,
    input  logic            mem_gnt_i,
    output logic [AW-1:0]   mem_addr_o,
    output logic [DW-1:0]   mem_wdata_o,
    output logic [DW/8-1:0] mem_be_o,
    output logic            busy_o,
    output logic            done_o
);

    localparam int BW = DW / 8;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [2*CW-1:0] total_q, acc_q;
    logic [CW-1:0]   cols_q, col_q;
    logic [AW-1:0]   stride_q, row_base_q;
    logic [DW-1:0]   buf_q [2];
    logic            wr_ptr_q, rd_ptr_q;
    logic [1:0]      occ_q;
    logic            push, pop, start_ok, zero_tile, last_push;

    assign start_ok    = (state_q == IDLE) && start_i;
    assign zero_tile   = (tile_rows_i == '0) || (tile_cols_i == '0);
    assign inp_ready_o = (state_q == RUN) && (occ_q != 2'd2) && (acc_q < total_q);
    assign push        = inp_valid_i && inp_ready_o;
    assign pop         = mem_req_o && mem_gnt_i;
    assign last_push   = push && ((acc_q + (2*CW)'(1)) == total_q);

    always_comb begin
        state_d = state_q;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = zero_tile ? DONE : RUN;
            end
            RUN: begin
                busy_o = 1'b1;
                if (last_push) state_d = DRAIN;
            end
            DRAIN: begin
                busy_o = 1'b1;
                // The popped beat is the last one once the buffer empties here.
                if (pop && (occ_q == 2'd1)) state_d = DONE;
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            total_q    <= '0;
            acc_q      <= '0;
            cols_q     <= '0;
            col_q      <= '0;
            stride_q   <= '0;
            row_base_q <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            occ_q      <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                total_q    <= (2*CW)'(tile_rows_i) * (2*CW)'(tile_cols_i);
                acc_q      <= '0;
                cols_q     <= tile_cols_i;
                stride_q   <= row_stride_i;
                row_base_q <= base_addr_i;
                col_q      <= '0;
            end
            if (push) begin
                acc_q    <= acc_q + (2*CW)'(1);
                wr_ptr_q <= ~wr_ptr_q;
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
            // Output-side address walk advances only on a granted beat.
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
                if (col_q == cols_q - CW'(1)) begin
                    col_q      <= '0;
                    row_base_q <= row_base_q + stride_q;
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end
        end
    end

    // Beat storage carries no reset; outputs are gated by occupancy instead.
    always_ff @(posedge clk_i) begin
        if (push) buf_q[wr_ptr_q] <= inp_data_i;
    end

    assign mem_req_o   = (occ_q != 2'd0);
    assign mem_addr_o  = mem_req_o ? (row_base_q + AW'(col_q) * AW'(BW)) : '0;
    assign mem_wdata_o = mem_req_o ? buf_q[rd_ptr_q] : '0;
    assign mem_be_o    = mem_req_o ? '1 : '0;

endmodule

// File: tb/tb_ita_output_writer.sv
// Directed bench for ita_output_writer: tile addressing, back-pressure, zero-size,
// protocol edges, address wrap and asynchronous reset mid-transfer.
module tb_ita_output_writer;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [31:0]  base_addr = '0;
    logic [31:0]  row_stride = '0;
    logic [15:0]  tile_rows = '0;
    logic [15:0]  tile_cols = '0;
    logic         inp_valid = 1'b0;
    logic         inp_ready;
    logic [127:0] inp_data = '0;
    logic         mem_req;
    logic         mem_gnt = 1'b0;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [15:0]  mem_be;
    logic         busy;
    logic         done;

    int nvec = 0;
    int nerr = 0;
    logic [31:0]  addr_log[$];
    logic [31:0]  exp_a [6] = '{32'h1000, 32'h1010, 32'h1020, 32'h1100, 32'h1110, 32'h1120};

    always #5 clk = ~clk;

    ita_output_writer dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .base_addr_i(base_addr), .row_stride_i(row_stride),
        .tile_rows_i(tile_rows), .tile_cols_i(tile_cols),
        .inp_valid_i(inp_valid), .inp_ready_o(inp_ready), .inp_data_i(inp_data),
        .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_be_o(mem_be),
        .busy_o(busy), .done_o(done)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, inp_ready, 0);
        chk({tag, "_req"},   mem_req,   0);
        chk({tag, "_addr"},  mem_addr,  0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_be"},    mem_be,    0);
        chk({tag, "_busy"},  busy,      0);
        chk({tag, "_done"},  done,      0);
    endtask

    function automatic logic [127:0] pat(input int i);
        return {16{8'(8'h10 + i)}};
    endfunction

    // Randomized valid/gnt tile run with a queue-based scoreboard.
    task automatic run_tile(input int rows, input int cols, input logic [31:0] base,
                            input logic [31:0] stride, input int pv, input int pg,
                            input string tag);
        logic [127:0] expq[$];
        logic [127:0] ed;
        logic [31:0]  ea;
        int n, issued, granted, cyc, busy_bad;
        bit seen_done, acc;
        n = rows * cols;
        addr_log.delete();
        @(negedge clk);
        start = 1'b1; tile_rows = 16'(rows); tile_cols = 16'(cols);
        base_addr = base; row_stride = stride;
        @(negedge clk);
        start = 1'b0; base_addr = 32'hDEAD_BEE0; row_stride = 32'h0BAD_0000;
        issued = 0; granted = 0; cyc = 0; busy_bad = 0; seen_done = 0;
        while (!seen_done && cyc < 20000) begin
            if (!inp_valid && issued < n && $urandom_range(99) < pv) begin
                inp_valid = 1'b1;
                inp_data = {$urandom, $urandom, $urandom, $urandom};
            end
            mem_gnt = ($urandom_range(99) < pg);
            #1;
            if (done) seen_done = 1;
            else if (!busy) busy_bad++;
            acc = inp_valid && inp_ready;
            if (acc) begin
                expq.push_back(inp_data);
                issued++;
            end
            if (mem_req && mem_gnt) begin
                ea = base + 32'(granted / cols) * stride + 32'(granted % cols) * 32'd16;
                ed = (expq.size() > 0) ? expq.pop_front() : '0;
                chk({tag, "_addr"}, mem_addr, ea);
                chk({tag, "_data"}, mem_wdata, ed);
                addr_log.push_back(mem_addr);
                granted++;
            end
            @(negedge clk);
            if (acc) inp_valid = 1'b0;
            cyc++;
        end
        inp_valid = 1'b0;
        mem_gnt = 1'b0;
        chk({tag, "_done_seen"}, seen_done, 1);
        chk({tag, "_beats"}, granted, n);
        chk({tag, "_busy_until_done"}, busy_bad, 0);
    endtask

    initial begin
        // Reset state
        #2 rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("rst");
        @(negedge clk);
        rst = 1'b0;

        // Valid in IDLE must not be consumed
        inp_valid = 1'b1; inp_data = 128'hBAD;
        #1 chk("idle_ready", inp_ready, 0);
        @(negedge clk);
        chk("idle_req", mem_req, 0);

        // Basic tile 2x3, gnt tied high, start re-pulsed mid-run
        start = 1'b1; tile_rows = 16'd2; tile_cols = 16'd3;
        base_addr = 32'h1000; row_stride = 32'h100; mem_gnt = 1'b1;
        inp_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = (i == 2);
            if (i == 2) begin tile_rows = '0; base_addr = 32'h9000; end
            if (i == 0) begin chk("basic_busy", busy, 1); base_addr = 32'h7000; end
            inp_valid = 1'b1; inp_data = pat(i);
            #1;
            chk("basic_ready", inp_ready, 1);
            if (i == 0) chk("basic_first_req", mem_req, 0);
            else begin
                chk("basic_req", mem_req, 1);
                chk("basic_addr", mem_addr, exp_a[i-1]);
                chk("basic_data", mem_wdata, pat(i-1));
                if (i == 1) chk("basic_be", mem_be, 16'hFFFF);
            end
        end
        @(negedge clk);
        start = 1'b0; inp_valid = 1'b0;
        #1;
        chk("basic_last_addr", mem_addr, exp_a[5]);
        chk("basic_last_data", mem_wdata, pat(5));
        chk("basic_drain_ready", inp_ready, 0);
        chk("basic_drain_busy", busy, 1);
        chk("basic_drain_done", done, 0);
        @(negedge clk);
        chk("basic_done", done, 1);
        chk("basic_done_busy", busy, 0);
        chk("basic_done_req", mem_req, 0);
        @(negedge clk);
        chk("basic_done_once", done, 0);

        // Back-pressure: 1x4 tile, gnt low for 5 cycles while valid held
        start = 1'b1; tile_rows = 16'd1; tile_cols = 16'd4;
        base_addr = 32'h2000; row_stride = 32'h0; mem_gnt = 1'b0;
        @(negedge clk);
        start = 1'b0; inp_valid = 1'b1; inp_data = pat(32);
        #1 chk("bp_ready0", inp_ready, 1);
        @(negedge clk);
        inp_data = pat(33);
        #1 chk("bp_ready1", inp_ready, 1);
        @(negedge clk);
        inp_data = pat(34);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("bp_ready_full", inp_ready, 0);
            chk("bp_req", mem_req, 1);
            chk("bp_addr_stable", mem_addr, 32'h2000);
            chk("bp_data_stable", mem_wdata, pat(32));
            @(negedge clk);
        end
        mem_gnt = 1'b1;
        #1 chk("bp_release_ready", inp_ready, 0);
        @(negedge clk);
        #1;
        chk("bp_b1_ready", inp_ready, 1);
        chk("bp_b1_addr", mem_addr, 32'h2010);
        chk("bp_b1_data", mem_wdata, pat(33));
        @(negedge clk);
        inp_data = pat(35);
        #1;
        chk("bp_b2_addr", mem_addr, 32'h2020);
        chk("bp_b2_data", mem_wdata, pat(34));
        @(negedge clk);
        inp_valid = 1'b0;
        #1;
        chk("bp_b3_addr", mem_addr, 32'h2030);
        chk("bp_b3_data", mem_wdata, pat(35));
        chk("bp_b3_ready", inp_ready, 0);
        @(negedge clk);
        chk("bp_done", done, 1);
        chk("bp_done_req", mem_req, 0);
        @(negedge clk);
        mem_gnt = 1'b0;

        // Zero-size tile
        start = 1'b1; tile_rows = 16'd0; tile_cols = 16'd5; inp_valid = 1'b1;
        #1 chk("zero_ready_t", inp_ready, 0);
        @(negedge clk);
        start = 1'b0;
        chk("zero_done", done, 1);
        chk("zero_req", mem_req, 0);
        chk("zero_ready", inp_ready, 0);
        chk("zero_busy", busy, 0);
        @(negedge clk);
        chk("zero_done_once", done, 0);
        chk("zero_req_after", mem_req, 0);
        inp_valid = 1'b0;

        // Address wrap at the top of the address space
        run_tile(1, 2, 32'hFFFF_FFF0, 32'h0, 100, 100, "wrap");
        chk("wrap_count", addr_log.size(), 2);
        if (addr_log.size() == 2) begin
            chk("wrap_a0", addr_log[0], 32'hFFFF_FFF0);
            chk("wrap_a1", addr_log[1], 32'h0000_0000);
        end

        // Random valid/gnt over a 25x40 tile
        run_tile(25, 40, 32'h0004_0000, 32'h0000_0400, 70, 60, "rand");

        // Reset after 3 of 6 beats, then a fresh tile
        @(negedge clk);
        start = 1'b1; tile_rows = 16'd2; tile_cols = 16'd3;
        base_addr = 32'h3000; row_stride = 32'h40; mem_gnt = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            inp_valid = 1'b1; inp_data = pat(64 + i);
            @(negedge clk);
        end
        inp_valid = 1'b0;
        #1 chk("mid_req_before", mem_req, 1);
        #1 rst = 1'b1;
        #1 chk_reset_outputs("mid_rst");
        @(negedge clk);
        chk("mid_no_done", done, 0);
        rst = 1'b0;
        mem_gnt = 1'b0;
        run_tile(2, 3, 32'h3000, 32'h40, 100, 100, "fresh");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
